chan_spim_tx: RTL

SPI master transmitter for the 16-channel register link. Each transmitted frame is 16 bits: a 4-bit channel number followed by a 12-bit value, MSB first, so a 16-channel SPI slave receiver can load `readings[chan]` when chip select deasserts. The block sits in the `clk` domain between fabric logic that produces channel values and the board pins `scs_n`, `sclk` and `sdat`.

---
 rtl/chan_spi_pkg.sv | 10 +
 rtl/spim_frame_engine.sv | 94 +++++++++
 rtl/chan_spim_tx.sv | 72 +++++++
 3 files changed

// File: rtl/chan_spi_pkg.sv
// chan_spi_pkg: shared widths, frame-engine states and frame packing for the 16-channel SPI link
package chan_spi_pkg;
  localparam int CHAN_W = 4;
  localparam int DATA_W = 12;
  localparam int FRAME_W = 16;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} spim_state_t;
  function automatic logic [FRAME_W-1:0] pack_frame(input logic [CHAN_W-1:0] chan, input logic [DATA_W-1:0] data);
    return {chan, data};
  endfunction
endpackage

// File: rtl/spim_frame_engine.sv
// spim_frame_engine: SETUP/SHIFT/GAP sequencer that serialises one 16-bit word MSB first per start
module spim_frame_engine
  import chan_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] word,
  output logic               idle,
  output logic               busy,
  output logic               done,
  output logic               scs_n,
  output logic               sclk,
  output logic               sdat
);
  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(CS_GAP + 1);
  spim_state_t state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [4:0] bit_q, bit_d;
  logic hi_q, hi_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic half_end, gap_end;
  assign half_end = half_q == HW'(CLK_DIV - 1);
  assign gap_end = gap_q == GW'(CS_GAP - 1);
  always_comb begin
    state_d = state_q;
    half_d = half_q;
    gap_d = gap_q;
    bit_d = bit_q;
    hi_d = hi_q;
    sh_d = sh_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        sh_d = word;
        half_d = '0;
      end
      SETUP: begin
        half_d = half_end ? '0 : half_q + 1'b1;
        if (half_end) begin
          state_d = SHIFT;
          hi_d = 1'b1;
          bit_d = '0;
        end
      end
      SHIFT: begin
        half_d = half_end ? '0 : half_q + 1'b1;
        if (half_end) begin
          hi_d = !hi_q;
          if (!hi_q && bit_q == 5'd15) begin
            state_d = GAP;
            gap_d = '0;
          end else if (!hi_q) begin
            bit_d = bit_q + 1'b1;
            sh_d = {sh_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      GAP: begin
        gap_d = gap_end ? '0 : gap_q + 1'b1;
        if (gap_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      half_q <= '0;
      gap_q <= '0;
      bit_q <= '0;
      hi_q <= 1'b0;
      sh_q <= '0;
    end else begin
      state_q <= state_d;
      half_q <= half_d;
      gap_q <= gap_d;
      bit_q <= bit_d;
      hi_q <= hi_d;
      sh_q <= sh_d;
    end
  end
  assign idle = state_q == IDLE;
  assign busy = !idle;
  assign done = state_q == GAP && gap_end;
  assign scs_n = !(state_q == SETUP || state_q == SHIFT);
  assign sclk = state_q == SHIFT && hi_q;
  assign sdat = !scs_n && sh_q[FRAME_W-1];
endmodule

// File: rtl/chan_spim_tx.sv
// chan_spim_tx: SPI master for the 16-channel register link; CHAN_SPIM_AUTOSCAN_EN adds shadow-file autoscan
module chan_spim_tx
  import chan_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CHAN_W-1:0] wr_chan,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              scs_n,
  output logic              sclk,
  output logic              sdat
);
  logic start, idle;
  logic [FRAME_W-1:0] word;
`ifdef CHAN_SPIM_AUTOSCAN_EN
  logic [DATA_W-1:0] shadow_q [16];
  logic [DATA_W-1:0] shadow_d [16];
  logic [15:0] pend_q, pend_d;
  logic [CHAN_W-1:0] ptr_q, ptr_d, sel;
  always_comb begin
    sel = ptr_q;
    for (int i = 15; i >= 0; i--) if (pend_q[i]) sel = CHAN_W'(i);
    shadow_d = shadow_q;
    pend_d = pend_q;
    ptr_d = ptr_q;
    if (idle && |pend_q) pend_d[sel] = 1'b0;
    if (idle && !(|pend_q)) ptr_d = ptr_q + 1'b1;
    // a same-cycle write re-arms the pending bit after the clear above
    if (wr_valid) begin
      shadow_d[wr_chan] = wr_data;
      pend_d[wr_chan] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_q <= '{default: '0};
      pend_q <= '0;
      ptr_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      pend_q <= pend_d;
      ptr_q <= ptr_d;
    end
  end
  assign start = 1'b1;
  assign word = pack_frame(sel, shadow_q[sel]);
  assign wr_ready = 1'b1;
`else
  assign start = wr_valid;
  assign word = pack_frame(wr_chan, wr_data);
  assign wr_ready = idle;
`endif
  spim_frame_engine #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) u_eng (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .word(word),
    .idle(idle),
    .busy(busy),
    .done(frame_done),
    .scs_n(scs_n),
    .sclk(sclk),
    .sdat(sdat)
  );
endmodule
